forwarding_scoreboard: RTL and testbench

- Sequencing and interlock controller for the operand forwarding network of the dual-issue integer pipeline.
- Tracks every in-flight register write across the forwarding stages: m1, m2, wb.
- For each source operand in the issue stage, chooses which forwarding bus slot supplies the value, or raises a stall when the producer's result is not yet available.
- Sits beside the issue stage. Its select outputs drive the per-operand forwarding muxes, and its stall output feeds the pipeline control.

---
 rtl/forwarding_pkg.sv | 25 ++
 rtl/fwd_operand_lookup.sv | 56 +++++
 rtl/forwarding_scoreboard.sv | 113 +++++++++++
 tb/tb_forwarding_scoreboard.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forwarding_pkg.sv
// Shared types and helpers for the operand forwarding scoreboard.
//   fwd_entry_t : one in-flight register write {valid, rd, ready_stage}
//   STAGE_*     : forwarding stage indices (m1, m2, wb)
//   slot_idx()  : forwarding bus slot number for a (stage, pipe) pair
package forwarding_pkg;

  localparam int STAGE_M1  = 0;
  localparam int STAGE_M2  = 1;
  localparam int STAGE_WB  = 2;

  localparam int FWD_RD_W  = 5;
  localparam int FWD_RDY_W = 2;

  typedef struct packed {
    logic                 valid;
    logic [FWD_RD_W-1:0]  rd;
    logic [FWD_RDY_W-1:0] ready_stage;
  } fwd_entry_t;

  // Bus slots are numbered stage-major so all m1 producers come first.
  function automatic int slot_idx(input int stage, input int pipe, input int pipe_num);
    return stage * pipe_num + pipe;
  endfunction

endpackage

// File: rtl/fwd_operand_lookup.sv
// Priority lookup of one source operand against every in-flight write.
// Ports:
//   i_rs, i_rs_used : source register and whether it is actually read
//   i_ent           : all entries flattened by slot_idx(stage, pipe)
//   o_hit           : operand is served from the forwarding bus
//   o_sel           : bus slot of the winning producer (0 when no hit)
//   o_not_ready     : youngest producer has not produced its result yet
module fwd_operand_lookup
  import forwarding_pkg::*;
#(
  parameter int PIPE_NUM   = 2,
  parameter int STAGE_NUM  = 3,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 3
) (
  input  logic [REG_ADDR_W-1:0]              i_rs,
  input  logic                               i_rs_used,
  input  fwd_entry_t [PIPE_NUM*STAGE_NUM-1:0] i_ent,
  output logic                               o_hit,
  output logic [SEL_W-1:0]                   o_sel,
  output logic                               o_not_ready
);

  logic                 w_found;
  logic [1:0]           w_win_stage;
  logic [SEL_W-1:0]     w_win_slot;
  logic [FWD_RDY_W-1:0] w_win_rdy;
  logic                 w_ready;

  // Scan oldest to youngest so the last match written is the youngest:
  // stages descending (wb first), pipes ascending within a stage.
  always_comb begin
    w_found     = 1'b0;
    w_win_stage = '0;
    w_win_slot  = '0;
    w_win_rdy   = '0;
    for (int s = STAGE_NUM - 1; s >= 0; s--) begin
      for (int p = 0; p < PIPE_NUM; p++) begin
        if (i_rs_used && (i_rs != '0) &&
            i_ent[slot_idx(s, p, PIPE_NUM)].valid &&
            (i_ent[slot_idx(s, p, PIPE_NUM)].rd == i_rs)) begin
          w_found     = 1'b1;
          w_win_stage = 2'(s);
          w_win_slot  = SEL_W'(slot_idx(s, p, PIPE_NUM));
          w_win_rdy   = i_ent[slot_idx(s, p, PIPE_NUM)].ready_stage;
        end
      end
    end
  end

  assign w_ready     = (w_win_rdy <= w_win_stage);
  assign o_hit       = w_found && w_ready;
  assign o_not_ready = w_found && !w_ready;
  assign o_sel       = o_hit ? w_win_slot : '0;

endmodule

// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard for the dual-issue integer pipeline.
// Tracks in-flight register writes through m1/m2/wb, picks the forwarding
// bus slot for every issue-stage source operand and raises a stall when a
// producer is not yet forwardable or when a bundle reads its own result.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   advance_i            : pipeline steps this cycle
//   flush_i              : kill all in-flight entries (wins over everything)
//   issue_*_i            : issue bundle (valid, rd, ready stage, sources)
//   fwd_hit_o, fwd_sel_o : per-operand forwarding mux controls
//   stall_o              : issue stage must hold
module forwarding_scoreboard
  import forwarding_pkg::*;
#(
  parameter int PIPE_NUM     = 2,
  parameter int STAGE_NUM    = 3,
  parameter int REG_ADDR_W   = 5,
  parameter int SRC_PER_PIPE = 2,
  localparam int SLOT_NUM    = PIPE_NUM * STAGE_NUM,
  localparam int SEL_W       = $clog2(SLOT_NUM)
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   advance_i,
  input  logic                                                   flush_i,
  input  logic [PIPE_NUM-1:0]                                    issue_valid_i,
  input  logic [PIPE_NUM-1:0][REG_ADDR_W-1:0]                    issue_rd_i,
  input  logic [PIPE_NUM-1:0][1:0]                               issue_ready_stage_i,
  input  logic [PIPE_NUM-1:0][SRC_PER_PIPE-1:0][REG_ADDR_W-1:0]  issue_rs_i,
  input  logic [PIPE_NUM-1:0][SRC_PER_PIPE-1:0]                  issue_rs_used_i,
  output logic [PIPE_NUM-1:0][SRC_PER_PIPE-1:0]                  fwd_hit_o,
  output logic [PIPE_NUM-1:0][SRC_PER_PIPE-1:0][SEL_W-1:0]       fwd_sel_o,
  output logic                                                   stall_o
);

  fwd_entry_t                              r_ent [STAGE_NUM][PIPE_NUM];
  fwd_entry_t [SLOT_NUM-1:0]               w_ent_flat;
  logic [PIPE_NUM-1:0][SRC_PER_PIPE-1:0]   w_not_ready;
  logic                                    w_intra;

  always_comb begin
    w_ent_flat = '0;
    for (int s = 0; s < STAGE_NUM; s++) begin
      for (int p = 0; p < PIPE_NUM; p++) begin
        w_ent_flat[slot_idx(s, p, PIPE_NUM)] = r_ent[s][p];
      end
    end
  end

  for (genvar gp = 0; gp < PIPE_NUM; gp++) begin : g_pipe
    for (genvar gk = 0; gk < SRC_PER_PIPE; gk++) begin : g_src
      fwd_operand_lookup #(
        .PIPE_NUM   (PIPE_NUM),
        .STAGE_NUM  (STAGE_NUM),
        .REG_ADDR_W (REG_ADDR_W),
        .SEL_W      (SEL_W)
      ) u_lookup (
        .i_rs        (issue_rs_i[gp][gk]),
        .i_rs_used   (issue_rs_used_i[gp][gk]),
        .i_ent       (w_ent_flat),
        .o_hit       (fwd_hit_o[gp][gk]),
        .o_sel       (fwd_sel_o[gp][gk]),
        .o_not_ready (w_not_ready[gp][gk])
      );
    end
  end

  // An older slot in the same bundle has no forwarding path to a younger
  // slot, so a same-bundle read-after-write can only be resolved by stalling.
  always_comb begin
    w_intra = 1'b0;
    for (int q = 1; q < PIPE_NUM; q++) begin
      for (int k = 0; k < SRC_PER_PIPE; k++) begin
        for (int p = 0; p < q; p++) begin
          if (issue_valid_i[p] && (issue_rd_i[p] != '0) &&
              issue_rs_used_i[q][k] && (issue_rs_i[q][k] == issue_rd_i[p])) begin
            w_intra = 1'b1;
          end
        end
      end
    end
  end

  assign stall_o = (|issue_valid_i) && ((|w_not_ready) || w_intra);

  // A stalled advance still drains m1..wb but inserts a bubble into m1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGE_NUM; s++) begin
        for (int p = 0; p < PIPE_NUM; p++) begin
          r_ent[s][p] <= '0;
        end
      end
    end else if (flush_i) begin
      for (int s = 0; s < STAGE_NUM; s++) begin
        for (int p = 0; p < PIPE_NUM; p++) begin
          r_ent[s][p].valid <= 1'b0;
        end
      end
    end else if (advance_i) begin
      for (int s = 1; s < STAGE_NUM; s++) begin
        for (int p = 0; p < PIPE_NUM; p++) begin
          r_ent[s][p] <= r_ent[s-1][p];
        end
      end
      for (int p = 0; p < PIPE_NUM; p++) begin
        r_ent[0][p] <= {issue_valid_i[p] && (issue_rd_i[p] != '0) && !stall_o,
                        issue_rd_i[p], issue_ready_stage_i[p]};
      end
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
module tb_forwarding_scoreboard;

  localparam int P  = 2;
  localparam int S  = 3;
  localparam int AW = 5;
  localparam int K  = 2;
  localparam int SW = 3;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         advance_i;
  logic                         flush_i;
  logic [P-1:0]                 issue_valid_i;
  logic [P-1:0][AW-1:0]         issue_rd_i;
  logic [P-1:0][1:0]            issue_ready_stage_i;
  logic [P-1:0][K-1:0][AW-1:0]  issue_rs_i;
  logic [P-1:0][K-1:0]          issue_rs_used_i;
  logic [P-1:0][K-1:0]          fwd_hit_o;
  logic [P-1:0][K-1:0][SW-1:0]  fwd_sel_o;
  logic                         stall_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a flat list of in-flight writes, each tagged with its age in
  // stages since issue (0 = m1) and the pipe it came from.
  typedef struct {
    int rd;
    int rdy;
    int age;
    int pipe;
  } prod_t;
  prod_t mq[$];

  forwarding_scoreboard #(
    .PIPE_NUM     (P),
    .STAGE_NUM    (S),
    .REG_ADDR_W   (AW),
    .SRC_PER_PIPE (K)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .advance_i           (advance_i),
    .flush_i             (flush_i),
    .issue_valid_i       (issue_valid_i),
    .issue_rd_i          (issue_rd_i),
    .issue_ready_stage_i (issue_ready_stage_i),
    .issue_rs_i          (issue_rs_i),
    .issue_rs_used_i     (issue_rs_used_i),
    .fwd_hit_o           (fwd_hit_o),
    .fwd_sel_o           (fwd_sel_o),
    .stall_o             (stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_lookup(input int rs, input bit used,
                                   output bit found, output bit hit, output int sel);
    int best_age  = 99;
    int best_pipe = -1;
    int best_rdy  = 0;
    found = 1'b0;
    hit   = 1'b0;
    sel   = 0;
    if (used && rs != 0) begin
      foreach (mq[i]) begin
        if (mq[i].rd == rs &&
            (mq[i].age < best_age || (mq[i].age == best_age && mq[i].pipe > best_pipe))) begin
          best_age  = mq[i].age;
          best_pipe = mq[i].pipe;
          best_rdy  = mq[i].rdy;
          found     = 1'b1;
        end
      end
    end
    if (found && best_rdy <= best_age) begin
      hit = 1'b1;
      sel = best_age * P + best_pipe;
    end
  endfunction

  function automatic bit m_stall();
    bit req = 1'b0;
    bit f, h;
    int sl;
    for (int p = 0; p < P; p++) begin
      for (int k = 0; k < K; k++) begin
        m_lookup(int'(issue_rs_i[p][k]), issue_rs_used_i[p][k], f, h, sl);
        if (f && !h) req = 1'b1;
        for (int o = 0; o < p; o++) begin
          if (issue_valid_i[o] && issue_rd_i[o] != 0 && issue_rs_used_i[p][k] &&
              issue_rs_i[p][k] == issue_rd_i[o]) req = 1'b1;
        end
      end
    end
    return (issue_valid_i != 0) && req;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < P; p++) begin
        for (int k = 0; k < K; k++) begin
          bit f, h;
          int sl;
          m_lookup(int'(issue_rs_i[p][k]), issue_rs_used_i[p][k], f, h, sl);
          check($sformatf("hit[%0d][%0d]", p, k), int'(fwd_hit_o[p][k]), int'(h));
          if (!f || h)
            check($sformatf("sel[%0d][%0d]", p, k), int'(fwd_sel_o[p][k]), sl);
        end
      end
      check("stall", int'(stall_o), int'(m_stall()));
    end
  end

  task automatic model_step();
    bit st;
    if (!rst_n || flush_i) begin
      mq.delete();
    end else if (advance_i) begin
      st = m_stall();
      foreach (mq[i]) mq[i].age++;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].age >= S) mq.delete(i);
      end
      if (!st) begin
        for (int p = 0; p < P; p++) begin
          if (issue_valid_i[p] && issue_rd_i[p] != 0) begin
            prod_t e;
            e.rd   = int'(issue_rd_i[p]);
            e.rdy  = int'(issue_ready_stage_i[p]);
            e.age  = 0;
            e.pipe = p;
            mq.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    advance_i           = 1'b1;
    flush_i             = 1'b0;
    issue_valid_i       = '0;
    issue_rd_i          = '0;
    issue_ready_stage_i = '0;
    issue_rs_i          = '0;
    issue_rs_used_i     = '0;
  endtask

  task automatic clear_pipe();
    idle();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic read_rs00(input int rs);
    idle();
    issue_valid_i[0]      = 1'b1;
    issue_rs_i[0][0]      = AW'(rs);
    issue_rs_used_i[0][0] = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #2;
    check("reset_hit", int'(fwd_hit_o), 0);
    check("reset_sel", int'(fwd_sel_o), 0);
    check("reset_stall", int'(stall_o), 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("post_reset_stall", int'(stall_o), 0);

    // Idle read with no writers.
    read_rs00(3);
    #1;
    check("idle_hit", int'(fwd_hit_o[0][0]), 0);
    check("idle_stall", int'(stall_o), 0);
    tick();

    // ALU producer forwards from m1 pipe0.
    clear_pipe();
    issue_valid_i[0] = 1'b1;
    issue_rd_i[0]    = 5'd5;
    tick();
    read_rs00(5);
    #1;
    check("alu_hit", int'(fwd_hit_o[0][0]), 1);
    check("alu_sel", int'(fwd_sel_o[0][0]), 0);
    check("alu_stall", int'(stall_o), 0);
    tick();

    // Load-use: stall once, then forward from m2 pipe0.
    clear_pipe();
    issue_valid_i[0]       = 1'b1;
    issue_rd_i[0]          = 5'd7;
    issue_ready_stage_i[0] = 2'd1;
    tick();
    read_rs00(7);
    #1;
    check("lu_stall", int'(stall_o), 1);
    check("lu_hit0", int'(fwd_hit_o[0][0]), 0);
    tick();
    check("lu_hit1", int'(fwd_hit_o[0][0]), 1);
    check("lu_sel1", int'(fwd_sel_o[0][0]), 2);
    check("lu_stall1", int'(stall_o), 0);
    tick();

    // Youngest producer wins on a shared rd.
    clear_pipe();
    issue_valid_i[1] = 1'b1;
    issue_rd_i[1]    = 5'd9;
    tick();
    idle();
    issue_valid_i[0] = 1'b1;
    issue_rd_i[0]    = 5'd9;
    tick();
    read_rs00(9);
    #1;
    check("young_hit", int'(fwd_hit_o[0][0]), 1);
    check("young_sel", int'(fwd_sel_o[0][0]), 0);
    tick();

    // Intra-bundle hazard, and r0 never stalls.
    clear_pipe();
    advance_i             = 1'b0;
    issue_valid_i         = 2'b11;
    issue_rd_i[0]         = 5'd4;
    issue_rs_i[1][0]      = 5'd4;
    issue_rs_used_i[1][0] = 1'b1;
    #1;
    check("intra_stall", int'(stall_o), 1);
    tick();
    issue_rd_i[0]    = 5'd0;
    issue_rs_i[1][0] = 5'd0;
    #1;
    check("intra_r0_stall", int'(stall_o), 0);
    tick();

    // Flush kills the pending load.
    clear_pipe();
    issue_valid_i[0]       = 1'b1;
    issue_rd_i[0]          = 5'd7;
    issue_ready_stage_i[0] = 2'd1;
    tick();
    idle();
    flush_i = 1'b1;
    tick();
    read_rs00(7);
    #1;
    check("flush_hit", int'(fwd_hit_o[0][0]), 0);
    check("flush_stall", int'(stall_o), 0);
    tick();

    // Asynchronous reset while stalled.
    clear_pipe();
    issue_valid_i[0]       = 1'b1;
    issue_rd_i[0]          = 5'd7;
    issue_ready_stage_i[0] = 2'd1;
    tick();
    read_rs00(7);
    #1;
    check("rst_pre_stall", int'(stall_o), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", int'(stall_o), 0);
    mq.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic with a small register space to force overlaps.
    for (int c = 0; c < 3000; c++) begin
      advance_i = ($urandom_range(0, 3) != 0);
      flush_i   = ($urandom_range(0, 31) == 0);
      for (int p = 0; p < P; p++) begin
        issue_valid_i[p]       = $urandom_range(0, 1) != 0;
        issue_rd_i[p]          = AW'($urandom_range(0, 7));
        issue_ready_stage_i[p] = 2'($urandom_range(0, 2));
        for (int k = 0; k < K; k++) begin
          issue_rs_i[p][k]      = AW'($urandom_range(0, 7));
          issue_rs_used_i[p][k] = $urandom_range(0, 1) != 0;
        end
      end
      tick();
    end

    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
